hazard_stall_unit: RTL and testbench

Pipeline stall/flush controller for the 5-stage rv32i core. It covers every hazard forwarding cannot resolve: load-use, instruction/data memory waits, and taken-branch redirects. It drives the pipeline register load enables, the ID/EX bubble select and the IF/ID and ID/EX flushes, and tracks wrong-path fetches still in flight. It also keeps saturating performance counters.

---
 rtl/hazard_stall_unit_if.sv | 37 +++
 rtl/hazard_stall_unit.sv | 101 ++++++++++
 tb/tb_hazard_stall_unit.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_unit_if.sv
// Hazard-unit bundle: decode/EX/MEM hazard inputs in, pipeline control words out.
// Signal names are taken from the hazard unit's point of view.
interface hazard_stall_unit_if;
  logic [4:0] ID_rs1_i;
  logic [4:0] ID_rs2_i;
  logic       ID_uses_rs1_i;
  logic       ID_uses_rs2_i;
  logic [4:0] EX_rd_i;
  logic [6:0] EX_opcode_i;
  logic       EX_br_taken_i;
  logic       IF_imem_pending_i;
  logic       MEM_dmem_req_i;
  logic       MEM_dmem_resp_i;

  logic       pc_load_o;
  logic       IF_ID_load_o;
  logic       ID_EX_load_o;
  logic       EX_MEM_load_o;
  logic       MEM_WB_load_o;
  logic       ID_EX_bubble_o;
  logic       IF_ID_flush_o;
  logic       ID_EX_flush_o;

  modport slave (
    input  ID_rs1_i, ID_rs2_i, ID_uses_rs1_i, ID_uses_rs2_i, EX_rd_i, EX_opcode_i,
           EX_br_taken_i, IF_imem_pending_i, MEM_dmem_req_i, MEM_dmem_resp_i,
    output pc_load_o, IF_ID_load_o, ID_EX_load_o, EX_MEM_load_o, MEM_WB_load_o,
           ID_EX_bubble_o, IF_ID_flush_o, ID_EX_flush_o
  );

  modport master (
    output ID_rs1_i, ID_rs2_i, ID_uses_rs1_i, ID_uses_rs2_i, EX_rd_i, EX_opcode_i,
           EX_br_taken_i, IF_imem_pending_i, MEM_dmem_req_i, MEM_dmem_resp_i,
    input  pc_load_o, IF_ID_load_o, ID_EX_load_o, EX_MEM_load_o, MEM_WB_load_o,
           ID_EX_bubble_o, IF_ID_flush_o, ID_EX_flush_o
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage rv32i pipeline, with saturating
// stall, bubble and flush performance counters.
module hazard_stall_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  hazard_stall_unit_if.slave hz,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] DRAIN   = 1'b1;
  localparam logic [6:0] OP_LOAD = 7'b0000011;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0] bubbleCnt_q, bubbleCnt_d;
  logic [CNT_W-1:0] flushCnt_q, flushCnt_d;
  logic             dstall, loadUse;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  assign dstall  = hz.MEM_dmem_req_i & ~hz.MEM_dmem_resp_i;
  assign loadUse = (hz.EX_opcode_i == OP_LOAD) && (hz.EX_rd_i != 5'd0) &&
                   ((hz.ID_uses_rs1_i && (hz.ID_rs1_i == hz.EX_rd_i)) ||
                    (hz.ID_uses_rs2_i && (hz.ID_rs2_i == hz.EX_rd_i)));

  // Priority: dstall freezes everything, a taken branch beats any decode hazard,
  // and in DRAIN the decode slot is wrong path so load-use is irrelevant.
  always_comb begin
    hz.pc_load_o      = 1'b1;
    hz.IF_ID_load_o   = 1'b1;
    hz.ID_EX_load_o   = 1'b1;
    hz.EX_MEM_load_o  = 1'b1;
    hz.MEM_WB_load_o  = 1'b1;
    hz.ID_EX_bubble_o = 1'b0;
    hz.IF_ID_flush_o  = 1'b0;
    hz.ID_EX_flush_o  = 1'b0;

    if (rst || dstall) begin
      hz.pc_load_o     = 1'b0;
      hz.IF_ID_load_o  = 1'b0;
      hz.ID_EX_load_o  = 1'b0;
      hz.EX_MEM_load_o = 1'b0;
      hz.MEM_WB_load_o = 1'b0;
    end else if (hz.EX_br_taken_i) begin
      hz.IF_ID_flush_o = 1'b1;
      hz.ID_EX_flush_o = 1'b1;
    end else if (state_q == DRAIN) begin
      hz.pc_load_o     = 1'b0;
      hz.IF_ID_flush_o = 1'b1;
    end else if (loadUse) begin
      hz.pc_load_o      = 1'b0;
      hz.IF_ID_load_o   = 1'b0;
      hz.ID_EX_bubble_o = 1'b1;
    end else if (hz.IF_imem_pending_i) begin
      hz.pc_load_o     = 1'b0;
      hz.IF_ID_flush_o = 1'b1;
    end
  end

  // DRAIN is left as soon as the stale fetch returns, even while MEM is stalled.
  always_comb begin
    state_d = state_q;
    if (state_q == DRAIN) begin
      state_d = hz.IF_imem_pending_i ? DRAIN : RUN;
    end else if (!dstall && hz.EX_br_taken_i && hz.IF_imem_pending_i) begin
      state_d = DRAIN;
    end
  end

  always_comb begin
    stallCnt_d  = satInc(stallCnt_q, ~hz.pc_load_o);
    bubbleCnt_d = satInc(bubbleCnt_q, hz.ID_EX_bubble_o);
    flushCnt_d  = satInc(flushCnt_q, hz.ID_EX_flush_o);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      stallCnt_q  <= '0;
      bubbleCnt_q <= '0;
      flushCnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      stallCnt_q  <= stallCnt_d;
      bubbleCnt_q <= bubbleCnt_d;
      flushCnt_q  <= flushCnt_d;
    end
  end

  assign stall_cnt_o  = stallCnt_q;
  assign bubble_cnt_o = bubbleCnt_q;
  assign flush_cnt_o  = flushCnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: vector table, directed multi-cycle
// sequences and a randomized run against a rule-level reference model.
module tb_hazard_stall_unit;
  localparam int CNT_W = 4;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_REG  = 7'b0110011;

  // Control word order: pc, IF/ID ld, ID/EX ld, EX/MEM ld, MEM/WB ld, bubble, IF/ID flush, ID/EX flush
  localparam logic [7:0] C_RUN    = 8'b11111_000;
  localparam logic [7:0] C_FREEZE = 8'b00000_000;
  localparam logic [7:0] C_BRANCH = 8'b11111_011;
  localparam logic [7:0] C_BUBBLE = 8'b00111_100;
  localparam logic [7:0] C_REFILL = 8'b01111_010;

  typedef struct {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] exRd;
    logic [6:0] exOp;
    logic       br;
    logic       pend;
    logic       req;
    logic       resp;
  } stim_t;

  typedef struct {
    stim_t      stim;
    logic [7:0] expCtrl;
  } vec_t;

  logic clk;
  logic rst;
  logic [CNT_W-1:0] stallCnt, bubbleCnt, flushCnt;
  int checkCnt = 0;
  int passCnt  = 0;

  hazard_stall_unit_if hazIf ();

  hazard_stall_unit #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .hz           (hazIf.slave),
    .stall_cnt_o  (stallCnt),
    .bubble_cnt_o (bubbleCnt),
    .flush_cnt_o  (flushCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                               input logic u2, input logic [4:0] rd, input logic [6:0] op,
                               input logic br, input logic pend, input logic req, input logic resp);
    stim_t s;
    s.rst = 1'b0; s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2;
    s.exRd = rd; s.exOp = op; s.br = br; s.pend = pend; s.req = req; s.resp = resp;
    return s;
  endfunction

  function automatic logic [7:0] ctrlNow();
    return {hazIf.pc_load_o, hazIf.IF_ID_load_o, hazIf.ID_EX_load_o, hazIf.EX_MEM_load_o,
            hazIf.MEM_WB_load_o, hazIf.ID_EX_bubble_o, hazIf.IF_ID_flush_o, hazIf.ID_EX_flush_o};
  endfunction

  // Reference: a register is hazardous when decode reads it and the load in EX writes it.
  function automatic logic refLoadUse(input stim_t s);
    logic readsHit;
    readsHit = (s.u1 && s.rs1 == s.exRd) || (s.u2 && s.rs2 == s.exRd);
    return (s.exOp == OP_LOAD) && (s.exRd != 0) && readsHit;
  endfunction

  function automatic logic [7:0] refCtrl(input stim_t s, input logic draining);
    if (s.rst) return C_FREEZE;
    if (s.req && !s.resp) return C_FREEZE;
    if (s.br) return C_BRANCH;
    if (draining) return C_REFILL;
    if (refLoadUse(s)) return C_BUBBLE;
    if (s.pend) return C_REFILL;
    return C_RUN;
  endfunction

  task automatic applyStimulus(input stim_t s);
    @(posedge clk);
    #1;
    rst                     = s.rst;
    hazIf.ID_rs1_i          = s.rs1;
    hazIf.ID_rs2_i          = s.rs2;
    hazIf.ID_uses_rs1_i     = s.u1;
    hazIf.ID_uses_rs2_i     = s.u2;
    hazIf.EX_rd_i           = s.exRd;
    hazIf.EX_opcode_i       = s.exOp;
    hazIf.EX_br_taken_i     = s.br;
    hazIf.IF_imem_pending_i = s.pend;
    hazIf.MEM_dmem_req_i    = s.req;
    hazIf.MEM_dmem_resp_i   = s.resp;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] expCtrl);
    logic [7:0] got;
    got = ctrlNow();
    checkCnt++;
    if (got === expCtrl) passCnt++;
    else $display("[TB] FAIL %s: ctrl got %b want %b", name, got, expCtrl);
  endtask

  task automatic checkCount(input string name, input logic [CNT_W-1:0] got, input int expVal);
    checkCnt++;
    if (got === CNT_W'(expVal)) passCnt++;
    else $display("[TB] FAIL %s: counter got %0d want %0d", name, got, expVal);
  endtask

  task automatic doReset();
    stim_t s;
    s = mk(0, 0, 0, 0, 0, OP_IMM, 0, 0, 0, 0);
    s.rst = 1'b1;
    applyStimulus(s);
  endtask

  vec_t  vecs[13];
  stim_t idle, lu, s;
  logic  drn;
  int    mStall, mBubble, mFlush;
  logic [7:0] e;

  initial begin
    idle = mk(0, 0, 0, 0, 0, OP_IMM, 0, 0, 0, 0);
    lu   = mk(5, 0, 1, 0, 5, OP_LOAD, 0, 0, 0, 0);

    vecs[0]  = '{mk(1, 2, 1, 1, 3, OP_REG,  0, 0, 0, 0), C_RUN};
    vecs[1]  = '{mk(5, 0, 1, 0, 5, OP_LOAD, 0, 0, 0, 0), C_BUBBLE};
    vecs[2]  = '{mk(0, 0, 1, 1, 0, OP_LOAD, 0, 0, 0, 0), C_RUN};
    vecs[3]  = '{mk(1, 7, 1, 0, 7, OP_LOAD, 0, 0, 0, 0), C_RUN};
    vecs[4]  = '{mk(1, 7, 1, 1, 7, OP_LOAD, 0, 0, 0, 0), C_BUBBLE};
    vecs[5]  = '{mk(6, 6, 1, 1, 6, OP_REG,  0, 0, 0, 0), C_RUN};
    vecs[6]  = '{mk(5, 0, 1, 0, 5, OP_LOAD, 0, 0, 1, 0), C_FREEZE};
    vecs[7]  = '{mk(1, 2, 1, 1, 3, OP_REG,  1, 1, 1, 0), C_FREEZE};
    vecs[8]  = '{mk(5, 0, 1, 0, 5, OP_LOAD, 1, 0, 0, 0), C_BRANCH};
    vecs[9]  = '{mk(1, 2, 1, 1, 3, OP_REG,  0, 1, 0, 0), C_REFILL};
    vecs[10] = '{mk(1, 2, 1, 1, 3, OP_REG,  1, 1, 0, 0), C_BRANCH};
    vecs[11] = '{mk(1, 2, 1, 1, 3, OP_REG,  0, 0, 1, 1), C_RUN};
    vecs[12] = '{mk(5, 0, 1, 0, 5, OP_LOAD, 0, 1, 0, 0), C_BUBBLE};

    rst = 1'b1;
    doReset();

    $display("[TB] reset and vector table");
    s = idle; s.rst = 1'b1;
    applyStimulus(s);
    checkOutput("rstOutputs", C_FREEZE);
    for (int i = 0; i < 13; i++) begin
      doReset();
      applyStimulus(vecs[i].stim);
      checkOutput($sformatf("vec%0d", i), vecs[i].expCtrl);
    end

    $display("[TB] load-use bubble");
    doReset();
    applyStimulus(lu);
    checkOutput("luBubble", C_BUBBLE);
    applyStimulus(idle);
    checkOutput("luAfter", C_RUN);
    checkCount("luBubbleCnt", bubbleCnt, 1);

    $display("[TB] dstall with load-use");
    doReset();
    s = lu; s.req = 1'b1; s.resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(s);
      checkOutput($sformatf("dstall%0d", i), C_FREEZE);
    end
    s.resp = 1'b1;
    applyStimulus(s);
    checkOutput("dstallResp", C_BUBBLE);
    applyStimulus(idle);
    checkCount("dstallStallCnt", stallCnt, 4);
    checkCount("dstallBubbleCnt", bubbleCnt, 1);

    $display("[TB] branch with fetch pending");
    doReset();
    s = idle; s.br = 1'b1; s.pend = 1'b1;
    applyStimulus(s);
    checkOutput("brTaken", C_BRANCH);
    s = lu; s.pend = 1'b1;
    applyStimulus(s);
    checkOutput("drainIgnoresLu", C_REFILL);
    s = idle; s.pend = 1'b1;
    applyStimulus(s);
    checkOutput("drainPend", C_REFILL);
    s.pend = 1'b0;
    applyStimulus(s);
    checkOutput("drainReturn", C_REFILL);
    applyStimulus(idle);
    checkOutput("backToRun", C_RUN);
    checkCount("brFlushCnt", flushCnt, 1);
    checkCount("brStallCnt", stallCnt, 3);

    $display("[TB] branch overrides load-use");
    doReset();
    s = lu; s.br = 1'b1;
    applyStimulus(s);
    checkOutput("brOverLu", C_BRANCH);
    applyStimulus(idle);
    checkCount("brOverLuBubble", bubbleCnt, 0);
    checkCount("brOverLuFlush", flushCnt, 1);

    $display("[TB] stall counter saturation");
    doReset();
    s = idle; s.pend = 1'b1;
    for (int i = 0; i < 20; i++) applyStimulus(s);
    applyStimulus(idle);
    checkCount("stallSat", stallCnt, 15);

    $display("[TB] reset during DRAIN");
    doReset();
    s = idle; s.br = 1'b1; s.pend = 1'b1;
    applyStimulus(s);
    s = lu; s.rst = 1'b1; s.br = 1'b1; s.pend = 1'b1;
    applyStimulus(s);
    checkOutput("rstInDrain", C_FREEZE);
    applyStimulus(idle);
    checkOutput("rstToRun", C_RUN);
    checkCount("rstStallCnt", stallCnt, 0);
    checkCount("rstFlushCnt", flushCnt, 0);
    checkCount("rstBubbleCnt", bubbleCnt, 0);

    $display("[TB] randomized run");
    drn = 1'b0; mStall = 0; mBubble = 0; mFlush = 0;
    for (int i = 0; i < 600; i++) begin
      s = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1) ? OP_LOAD : OP_REG,
             1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
      s.rst = (i == 0) || ($urandom_range(0, 39) == 0);
      applyStimulus(s);
      e = refCtrl(s, drn);
      checkOutput($sformatf("rnd%0d", i), e);
      if (i > 0) begin
        checkCount($sformatf("rndStall%0d", i), stallCnt, mStall);
        checkCount($sformatf("rndBubble%0d", i), bubbleCnt, mBubble);
        checkCount($sformatf("rndFlush%0d", i), flushCnt, mFlush);
      end
      if (s.rst) begin
        drn = 1'b0; mStall = 0; mBubble = 0; mFlush = 0;
      end else begin
        if (!e[7] && mStall < 15) mStall++;
        if (e[2] && mBubble < 15) mBubble++;
        if (e[0] && mFlush < 15) mFlush++;
        drn = drn ? s.pend : (!(s.req && !s.resp) && s.br && s.pend);
      end
    end

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end
endmodule
